// File: rtl/relobi_sram_sbr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : relobi_sram_sbr_pkg
// Description : Shared types, widths and Hsiao SEC-DED helpers for the
//               reliable-OBI SRAM subordinate.
// Revision    : 1.0 - initial release
// ============================================================================
package relobi_sram_sbr_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 4;
  // Seven check bits cover both the 32-bit address and the 37-bit r payload.
  localparam int unsigned EccWidth  = 7;
  localparam int unsigned EccMaxK   = 1 + IdWidth + DataWidth;

  typedef struct packed {
    logic [AddrWidth+EccWidth-1:0] addr;   // {check bits, address}
    logic                          we;
    logic [DataWidth/8-1:0]        be;
    logic [DataWidth-1:0]          wdata;
    logic [IdWidth-1:0]            aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic [2:0]  req;
    obi_a_chan_t a;
    logic [2:0]  rready;
  } obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
    logic [EccWidth-1:0]  ecc;
  } obi_r_chan_t;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  // One buffered response; its packed layout {err, rid, rdata} is what the r-channel code protects.
  typedef struct packed {
    logic                 err;
    logic [IdWidth-1:0]   rid;
    logic [DataWidth-1:0] rdata;
  } rsp_entry_t;

  typedef logic [EccMaxK-1:0][EccWidth-1:0] hsiao_mat_t;

  typedef struct packed {
    logic [EccMaxK-1:0] data;
    logic               sec;
    logic               ded;
  } hsiao_dec_t;

  // Data columns: all weight-3 patterns in ascending order, then weight-5 ones.
  function automatic hsiao_mat_t hsiao_gen_cols();
    hsiao_mat_t  cols;
    int unsigned n;
    cols = '0;
    n    = 0;
    for (int w = 3; w <= 5; w += 2) begin
      for (int v = 1; v < 128; v++) begin
        if (($countones(7'(v)) == w) && (n < EccMaxK)) begin
          cols[n] = 7'(v);
          n++;
        end
      end
    end
    return cols;
  endfunction

  localparam hsiao_mat_t HsiaoCols = hsiao_gen_cols();

  function automatic logic [EccWidth-1:0] hsiao_parity(input logic [EccMaxK-1:0] data);
    logic [EccWidth-1:0] p;
    p = '0;
    for (int i = 0; i < EccMaxK; i++) begin
      if (data[i]) p ^= HsiaoCols[i];
    end
    return p;
  endfunction

  // Only the low k data columns exist in the codeword; a syndrome hitting a
  // padding column is treated as uncorrectable.
  function automatic hsiao_dec_t hsiao_dec(input logic [EccMaxK-1:0] data,
                                           input logic [EccWidth-1:0] parity,
                                           input int unsigned         k);
    hsiao_dec_t          res;
    logic [EccWidth-1:0] syn;
    logic                hit;
    syn      = hsiao_parity(data) ^ parity;
    hit      = 1'b0;
    res.data = data;
    res.sec  = 1'b0;
    res.ded  = 1'b0;
    for (int i = 0; i < EccMaxK; i++) begin
      if ((i < k) && (syn == HsiaoCols[i])) begin
        res.data[i] = ~data[i];
        hit         = 1'b1;
      end
    end
    if (syn != '0) begin
      if ($countones(syn) == 1) hit = 1'b1;
      if (hit) res.sec = 1'b1;
      else     res.ded = 1'b1;
    end
    return res;
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/relobi_sram_sbr_rsp_buf.sv
`default_nettype none
// ============================================================================
// Module      : relobi_sram_sbr_rsp_buf
// Description : In-order response FIFO with fall-through when empty, plus the
//               r-channel Hsiao encoder at its output.
// Revision    : 1.0 - initial release
// ============================================================================
module relobi_sram_sbr_rsp_buf
  import relobi_sram_sbr_pkg::*;
#(
  parameter int unsigned NumMaxTrans = 2,
  localparam int unsigned UsageWidth = $clog2(NumMaxTrans + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  rsp_entry_t            data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [UsageWidth-1:0] usage_o,
  output obi_r_chan_t           r_o
);

  localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;

  rsp_entry_t            mem_q [NumMaxTrans];
  logic [PtrWidth-1:0]   rptr_q, wptr_q;
  logic [UsageWidth-1:0] usage_q;
  logic                  store, pop_mem;
  rsp_entry_t            head;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(NumMaxTrans - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // An entry arriving into an empty buffer while being popped passes straight through.
  always_comb begin
    store   = push_i & ~((usage_q == '0) & pop_i);
    pop_mem = pop_i & (usage_q != '0);
    head    = (usage_q == '0) ? data_i : mem_q[rptr_q];
    empty_o = (usage_q == '0) & ~push_i;
    full_o  = (usage_q == UsageWidth'(NumMaxTrans));
    usage_o = usage_q;
    r_o.rdata = head.rdata;
    r_o.rid   = head.rid;
    r_o.err   = head.err;
    r_o.ecc   = hsiao_parity(head);
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (store) mem_q[wptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      usage_q <= '0;
    end else begin
      if (store)   wptr_q <= ptr_inc(wptr_q);
      if (pop_mem) rptr_q <= ptr_inc(rptr_q);
      case ({store, pop_mem})
        2'b10:   usage_q <= usage_q + UsageWidth'(1);
        2'b01:   usage_q <= usage_q - UsageWidth'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/relobi_sram_sbr.sv
`default_nettype none
// ============================================================================
// Module      : relobi_sram_sbr
// Description : Reliable-OBI subordinate driving a single-port SRAM. Votes the
//               TMR handshake, corrects the address, limits outstanding
//               transactions by credits and reports faults.
// Revision    : 1.0 - initial release
// ============================================================================
module relobi_sram_sbr
  import relobi_sram_sbr_pkg::*;
#(
  parameter bit                   UseRReady     = 1'b1,
  parameter int unsigned          SramAddrWidth = 10,
  parameter int unsigned          NumMaxTrans   = 2,
  parameter logic [DataWidth-1:0] ErrData       = 32'hBADCAB1E
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  obi_req_t                 obi_req_i,
  output obi_rsp_t                 obi_rsp_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [SramAddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [DataWidth/8-1:0]   sram_be_o,
  input  logic [DataWidth-1:0]     sram_rdata_i,
  output logic [1:0]               fault_o
);

  localparam int unsigned UsageWidth  = $clog2(NumMaxTrans + 1);
  localparam int unsigned CreditWidth = UsageWidth + 1;

  logic                  req_v, rready_v, grant_ok, accept, pop, tmr_fault;
  hsiao_dec_t            addr_dec;
  logic                  inflight_q, we_q, err_q;
  logic [IdWidth-1:0]    aid_q;
  logic [1:0]            fault_q, fault_d;
  rsp_entry_t            push_data;
  logic                  buf_full, buf_empty;
  logic [UsageWidth-1:0] buf_usage;
  obi_r_chan_t           r_chan;
  logic                  unused_addr_bits;

  // Voting, address correction, credit check and SRAM drive.
  always_comb begin
    req_v     = maj3(obi_req_i.req);
    rready_v  = UseRReady ? maj3(obi_req_i.rready) : 1'b1;
    addr_dec  = hsiao_dec(EccMaxK'(obi_req_i.a.addr[AddrWidth-1:0]),
                          obi_req_i.a.addr[AddrWidth +: EccWidth], AddrWidth);
    // The in-flight access already owns a buffer slot for its response.
    grant_ok  = rst_ni & ~buf_full &
                ((CreditWidth'(buf_usage) + CreditWidth'(inflight_q)) < CreditWidth'(NumMaxTrans));
    accept    = req_v & grant_ok;
    pop       = rst_ni & ~buf_empty & rready_v;

    sram_req_o   = accept & ~addr_dec.ded;
    sram_we_o    = obi_req_i.a.we;
    sram_addr_o  = addr_dec.data[SramAddrWidth+1:2];
    sram_wdata_o = obi_req_i.a.wdata;
    sram_be_o    = obi_req_i.a.be;

    push_data.err   = err_q;
    push_data.rid   = aid_q;
    push_data.rdata = err_q ? ErrData : (we_q ? '0 : sram_rdata_i);

    tmr_fault  = ((obi_req_i.req != 3'b000) && (obi_req_i.req != 3'b111)) ||
                 (UseRReady && (obi_req_i.rready != 3'b000) && (obi_req_i.rready != 3'b111));
    fault_d    = 2'b00;
    fault_d[0] = tmr_fault | (req_v & addr_dec.sec);
    fault_d[1] = req_v & addr_dec.ded;

    obi_rsp_o.gnt    = {3{accept}};
    obi_rsp_o.rvalid = {3{rst_ni & ~buf_empty}};
    obi_rsp_o.r      = r_chan;
    fault_o          = fault_q;
  end

  assign unused_addr_bits = ^{addr_dec.data[EccMaxK-1:SramAddrWidth+2], addr_dec.data[1:0]};

  // Track the access whose SRAM data returns next cycle and register fault flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      aid_q      <= '0;
      fault_q    <= 2'b00;
    end else begin
      inflight_q <= accept;
      fault_q    <= fault_d;
      if (accept) begin
        we_q  <= obi_req_i.a.we;
        err_q <= addr_dec.ded;
        aid_q <= obi_req_i.a.aid;
      end
    end
  end

  relobi_sram_sbr_rsp_buf #(
    .NumMaxTrans(NumMaxTrans)
  ) i_rsp_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  (push_data),
    .pop_i   (pop),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .usage_o (buf_usage),
    .r_o     (r_chan)
  );

endmodule
`default_nettype wire
